// File: rtl/mod113_w80_digit_decoder_if.sv
// mod113_w80_digit_decoder_if: residue-in / digit-out valid-ready stream pair
interface mod113_w80_digit_decoder_if #(
  parameter int RES_W = 7,
  parameter int DIG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_res;
  logic             out_valid;
  logic             out_ready;
  logic [DIG_W-1:0] out_digit;
  logic             out_err;
  modport master (
    output in_valid, in_res, out_ready,
    input  in_ready, out_valid, out_digit, out_err
  );
  modport slave (
    input  in_valid, in_res, out_ready,
    output in_ready, out_valid, out_digit, out_err
  );
endinterface

// File: rtl/mod113_w80_digit_decoder.sv
// mod113_w80_digit_decoder: recovers d from r = (d*80) mod 113 via bit-serial d = (r*89) mod 113
module mod113_w80_digit_decoder #(
  parameter int MODULUS    = 113,
  parameter int INV_WEIGHT = 89,
  parameter int RES_W      = 7,
  parameter int DIG_W      = 6
) (
  input logic clk,
  input logic rst_n,
  mod113_w80_digit_decoder_if.slave bus
);
  localparam int CW = $clog2(RES_W);
  localparam int TW = RES_W + 2;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [RES_W-1:0] r, acc;
  logic [CW-1:0] cnt;
  logic range_err, err, red_err;
  logic [DIG_W-1:0] digit;
  logic [TW-1:0] t, t1, red;
  // Horner step: 2*acc + bit*inverse stays below 3*MODULUS, so two conditional subtracts suffice
  always_comb begin
    t = TW'({acc, 1'b0}) + (r[cnt] ? TW'(INV_WEIGHT) : '0);
    t1 = t >= TW'(MODULUS) ? t - TW'(MODULUS) : t;
    red = t1 >= TW'(MODULUS) ? t1 - TW'(MODULUS) : t1;
    red_err = range_err | (red >= TW'(2 ** DIG_W));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (bus.in_valid ? CALC : IDLE) :
               state == CALC ? (cnt == '0 ? DONE : CALC) :
               (bus.out_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    bus.out_digit = digit;
    bus.out_err = err;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r <= '0;
      acc <= '0;
      cnt <= '0;
      range_err <= 1'b0;
      err <= 1'b0;
      digit <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      r <= bus.in_res;
      acc <= '0;
      cnt <= CW'(RES_W - 1);
      range_err <= TW'(bus.in_res) >= TW'(MODULUS);
    end else if (state == CALC) begin
      acc <= red[RES_W-1:0];
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        err <= red_err;
        digit <= red_err ? '0 : red[DIG_W-1:0];
      end
    end
endmodule

// File: tb/tb_mod113_w80_digit_decoder.sv
// tb_mod113_w80_digit_decoder: scoreboard bench, directed vectors then a full residue sweep
module tb_mod113_w80_digit_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mod113_w80_digit_decoder_if bus ();
  mod113_w80_digit_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [6:0] r; logic err; logic [5:0] d;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit rdy_rand = 1'b0;
  bit rdy_fixed = 1'b1;
  bit got_valid [128];
  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end
  always @(negedge clk)
    if (rst_n) assert (dut.acc < 7'd113) else $error("FAIL acc_range: acc %0d not below 113", dut.acc);
  initial begin
    logic [5:0] ld;
    logic le;
    bit held;
    exp_t e;
    ld = '0;
    le = 1'b0;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ld = '0;
        le = 1'b0;
        held = 1'b0;
      end else if (!bus.out_valid) begin
        check("hold_digit", bus.out_digit, ld);
        check("hold_err", bus.out_err, le);
      end else begin
        check("no_overlap", bus.in_ready, 0);
        if (held) begin
          check("stable_digit", bus.out_digit, ld);
          check("stable_err", bus.out_err, le);
        end
        ld = bus.out_digit;
        le = bus.out_err;
        held = !bus.out_ready;
        if (bus.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: digit %0d err %0d, expected no output", bus.out_digit, bus.out_err);
          end else begin
            e = q.pop_front();
            check($sformatf("digit r=%0d", e.r), bus.out_digit, e.d);
            check($sformatf("err r=%0d", e.r), bus.out_err, e.err);
            if (!bus.out_err) begin
              got_valid[e.r] = 1'b1;
              check("roundtrip", (int'(bus.out_digit) * 80) % 113, e.r);
            end
          end
        end
      end
    end
  end
  task automatic send(input logic [6:0] r, input logic [5:0] d, input logic err, input bit lat);
    int n;
    bit ok;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_res = r;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout r=%0d: in_ready 0, required 1", r);
      return;
    end
    q.push_back(exp_t'{r: r, err: err, d: d});
    bus.in_res = 7'($urandom);
    if (lat) begin
      n = 0;
      while (!bus.out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check($sformatf("latency r=%0d", r), n, 7);
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int m;
    bit e;
    bit code;
    bus.in_valid = 1'b0;
    bus.in_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_digit", bus.out_digit, 0);
    check("rst_out_err", bus.out_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(7'd80, 6'd1, 1'b0, 1'b1);
    send(7'd0, 6'd0, 1'b0, 1'b0);
    send(7'd68, 6'd63, 1'b0, 1'b0);
    send(7'd112, 6'd24, 1'b0, 1'b1);
    send(7'd35, 6'd0, 1'b1, 1'b0);
    send(7'd113, 6'd0, 1'b1, 1'b1);
    send(7'd127, 6'd0, 1'b1, 1'b1);
    drain();
    rdy_fixed = 1'b0;
    send(7'd68, 6'd63, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i % 3) == 0;
      bus.in_res = 7'd80;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_res = 7'd112;
    rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    check("release_idle", bus.in_ready, 1);
    @(posedge clk);
    #1;
    check("release_accept", bus.in_ready, 0);
    q.push_back(exp_t'{r: 7'd112, err: 1'b0, d: 6'd24});
    bus.in_valid = 1'b0;
    drain();
    send(7'd80, 6'd1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_digit", bus.out_digit, 0);
    check("midrst_out_err", bus.out_err, 0);
    void'(q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("midrst_no_output", bus.out_valid, 0);
    end
    send(7'd68, 6'd63, 1'b0, 1'b1);
    drain();
    rdy_rand = 1'b1;
    for (int r = 0; r < 128; r++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      m = (r * 89) % 113;
      e = r >= 113 || m >= 64;
      send(7'(r), e ? 6'd0 : 6'(m), e, 1'b0);
    end
    drain();
    rdy_rand = 1'b0;
    for (int r = 0; r < 128; r++) begin
      code = 1'b0;
      for (int d = 0; d < 64; d++) if ((d * 80) % 113 == r) code = 1'b1;
      check($sformatf("valid_set r=%0d", r), got_valid[r], code);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
